// File: rtl/sa_aw_channel.sv
// Slave-side AW arbiter: round-robin grant over dispatchers into a one-entry registered AW slot.
// Define SA_AW_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module sa_aw_channel #(
    parameter int MST_AMT          = 3,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int TRANS_ID_W       = 5,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic                                 ACLK_i,
    input  logic                                 ARESETn_i,
    input  logic [TRANS_ID_W*MST_AMT-1:0]        dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AWADDR_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AWLEN_i,
    input  logic [MST_AMT-1:0]                   dsp_AWVALID_i,
    input  logic [MST_AMT-1:0]                   dsp_slv_sel_i,
    output logic [MST_AMT-1:0]                   dsp_AWREADY_o,
    output logic [MST_ID_W+TRANS_ID_W-1:0]       s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                s_AWADDR_o,
    output logic [TRANS_DATA_LEN_W-1:0]          s_AWLEN_o,
    output logic                                 s_AWVALID_o,
    input  logic                                 s_AWREADY_i,
    input  logic                                 AW_stall_i,
    output logic [MST_ID_W-1:0]                  AW_mst_id_o,
    output logic [TRANS_DATA_LEN_W-1:0]          AW_AxLEN_o,
    output logic                                 AW_fifo_order_wr_en_o,
    input  logic                                 B_done_i
);

    localparam int OST_W = $clog2(OUTSTANDING_AMT + 1);

    logic [MST_AMT-1:0]          req;
    logic                        slot_free;
    logic                        ost_full;
    logic                        accept;
    logic [OST_W-1:0]            ost_cnt;
    logic [MST_ID_W-1:0]         grant;
    logic [MST_ID_W-1:0]         lo_g;
    logic [TRANS_ID_W-1:0]       sel_id;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [TRANS_DATA_LEN_W-1:0] sel_len;

    assign req       = dsp_AWVALID_i & dsp_slv_sel_i;
    assign slot_free = ~s_AWVALID_o | s_AWREADY_i;
    assign ost_full  = (ost_cnt == OST_W'(OUTSTANDING_AMT));
    assign accept    = (|req) & slot_free & ~AW_stall_i & ~ost_full;

`ifdef SA_AW_FIXED_PRIORITY_EN
    always_comb begin
        lo_g = '0;
        for (int i = MST_AMT - 1; i >= 0; i--) begin
            if (req[i]) lo_g = MST_ID_W'(i);
        end
    end

    assign grant = lo_g;
`else
    logic [MST_ID_W-1:0] rr_ptr;
    logic [MST_ID_W-1:0] hi_g;
    logic                hi_found;

    // Downward scan leaves the lowest requester overall (wrap-around case) and the
    // lowest requester at or above rr_ptr (preferred, no wrap).
    always_comb begin
        lo_g     = '0;
        hi_g     = '0;
        hi_found = 1'b0;
        for (int i = MST_AMT - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_g = MST_ID_W'(i);
                if (MST_ID_W'(i) >= rr_ptr) begin
                    hi_g     = MST_ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign grant = hi_found ? hi_g : lo_g;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant == MST_ID_W'(MST_AMT - 1)) ? '0 : grant + 1'b1;
    end
`endif

    always_comb begin
        sel_id        = '0;
        sel_addr      = '0;
        sel_len       = '0;
        dsp_AWREADY_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (MST_ID_W'(i) == grant) begin
                sel_id           = dsp_AWID_i[i*TRANS_ID_W +: TRANS_ID_W];
                sel_addr         = dsp_AWADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len          = dsp_AWLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                dsp_AWREADY_o[i] = accept;
            end
        end
    end

    assign AW_fifo_order_wr_en_o = accept;
    assign AW_mst_id_o           = grant;
    assign AW_AxLEN_o            = sel_len;

    // A stalled slot (valid, no ready) never satisfies slot_free, so fields stay put.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AWVALID_o <= 1'b0;
            s_AWID_o    <= '0;
            s_AWADDR_o  <= '0;
            s_AWLEN_o   <= '0;
        end else if (accept) begin
            s_AWVALID_o <= 1'b1;
            s_AWID_o    <= {grant, sel_id};
            s_AWADDR_o  <= sel_addr;
            s_AWLEN_o   <= sel_len;
        end else if (s_AWVALID_o && s_AWREADY_i) begin
            s_AWVALID_o <= 1'b0;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i)
            ost_cnt <= '0;
        else if (accept && !(B_done_i && ost_cnt != '0))
            ost_cnt <= ost_cnt + 1'b1;
        else if (!accept && B_done_i && ost_cnt != '0)
            ost_cnt <= ost_cnt - 1'b1;
    end

endmodule

// File: tb/tb_sa_aw_channel.sv
// Directed bench for sa_aw_channel (3 masters, outstanding limit 2) with immediate-assertion checks.
module tb_sa_aw_channel;

    localparam int MST  = 3;
    localparam int TIDW = 5;
    localparam int AW   = 32;
    localparam int LW   = 3;
    localparam int MIDW = 2;

    logic                 ACLK_i = 1'b0;
    logic                 ARESETn_i;
    logic [TIDW*MST-1:0]  dsp_AWID_i;
    logic [AW*MST-1:0]    dsp_AWADDR_i;
    logic [LW*MST-1:0]    dsp_AWLEN_i;
    logic [MST-1:0]       dsp_AWVALID_i;
    logic [MST-1:0]       dsp_slv_sel_i;
    logic [MST-1:0]       dsp_AWREADY_o;
    logic [MIDW+TIDW-1:0] s_AWID_o;
    logic [AW-1:0]        s_AWADDR_o;
    logic [LW-1:0]        s_AWLEN_o;
    logic                 s_AWVALID_o;
    logic                 s_AWREADY_i;
    logic                 AW_stall_i;
    logic [MIDW-1:0]      AW_mst_id_o;
    logic [LW-1:0]        AW_AxLEN_o;
    logic                 AW_fifo_order_wr_en_o;
    logic                 B_done_i;

    int vectorCount = 0;
    int missCount   = 0;

    sa_aw_channel #(
        .MST_AMT(MST), .OUTSTANDING_AMT(2), .MST_ID_W(MIDW),
        .TRANS_ID_W(TIDW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW)
    ) dut (
        .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
        .dsp_AWID_i(dsp_AWID_i), .dsp_AWADDR_i(dsp_AWADDR_i), .dsp_AWLEN_i(dsp_AWLEN_i),
        .dsp_AWVALID_i(dsp_AWVALID_i), .dsp_slv_sel_i(dsp_slv_sel_i),
        .dsp_AWREADY_o(dsp_AWREADY_o),
        .s_AWID_o(s_AWID_o), .s_AWADDR_o(s_AWADDR_o), .s_AWLEN_o(s_AWLEN_o),
        .s_AWVALID_o(s_AWVALID_o), .s_AWREADY_i(s_AWREADY_i),
        .AW_stall_i(AW_stall_i), .AW_mst_id_o(AW_mst_id_o), .AW_AxLEN_o(AW_AxLEN_o),
        .AW_fifo_order_wr_en_o(AW_fifo_order_wr_en_o), .B_done_i(B_done_i)
    );

    always #5 ACLK_i = ~ACLK_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic v, input logic [TIDW-1:0] id,
                                 input logic [AW-1:0] addr, input logic [LW-1:0] len);
        dsp_AWVALID_i[m]           = v;
        dsp_AWID_i[m*TIDW +: TIDW] = id;
        dsp_AWADDR_i[m*AW +: AW]   = addr;
        dsp_AWLEN_i[m*LW +: LW]    = len;
    endtask

    task automatic doReset();
        dsp_AWID_i    = '0;
        dsp_AWADDR_i  = '0;
        dsp_AWLEN_i   = '0;
        dsp_AWVALID_i = '0;
        dsp_slv_sel_i = 3'b111;
        s_AWREADY_i   = 1'b0;
        AW_stall_i    = 1'b0;
        B_done_i      = 1'b0;
        ARESETn_i     = 1'b0;
        @(posedge ACLK_i); #1;
        ARESETn_i     = 1'b1;
    endtask

    task automatic tick();
        @(posedge ACLK_i); #1;
    endtask

    initial begin
        doReset();
        checkOutput("rst_valid",  64'(s_AWVALID_o), 64'd0);
        checkOutput("rst_awid",   64'(s_AWID_o), 64'd0);
        checkOutput("rst_addr",   64'(s_AWADDR_o), 64'd0);
        checkOutput("rst_ready",  64'(dsp_AWREADY_o), 64'd0);
        checkOutput("rst_wr_en",  64'(AW_fifo_order_wr_en_o), 64'd0);

        // Single request from master 1
        $display("[TB] step 1: single grant");
        applyStimulus(1, 1'b1, 5'd5, 32'h100, 3'd3);
        s_AWREADY_i = 1'b1;
        #1;
        checkOutput("t1_ready",  64'(dsp_AWREADY_o), 64'b010);
        checkOutput("t1_wr_en",  64'(AW_fifo_order_wr_en_o), 64'd1);
        checkOutput("t1_mst_id", 64'(AW_mst_id_o), 64'd1);
        checkOutput("t1_axlen",  64'(AW_AxLEN_o), 64'd3);
        tick();
        dsp_AWVALID_i = '0;
        checkOutput("t1_svalid", 64'(s_AWVALID_o), 64'd1);
        checkOutput("t1_sawid",  64'(s_AWID_o), 64'h25);
        checkOutput("t1_saddr",  64'(s_AWADDR_o), 64'h100);
        checkOutput("t1_slen",   64'(s_AWLEN_o), 64'd3);

        // Round-robin with all masters requesting
        $display("[TB] step 2: round robin");
        doReset();
        for (int i = 0; i < MST; i++)
            applyStimulus(i, 1'b1, TIDW'(i + 1), 32'h1000 + 32'(i) * 32'h10, LW'(i));
        s_AWREADY_i = 1'b1;
        B_done_i    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput("t2_ready", 64'(dsp_AWREADY_o), 64'(3'b001 << (k % 3)));
            checkOutput("t2_mst",   64'(AW_mst_id_o), 64'(k % 3));
            tick();
            checkOutput("t2_svalid", 64'(s_AWVALID_o), 64'd1);
            checkOutput("t2_saddr",  64'(s_AWADDR_o), 64'h1000 + 64'(k % 3) * 64'h10);
            checkOutput("t2_sawid",  64'(s_AWID_o), 64'({2'(k % 3), 5'(k % 3 + 1)}));
        end

        // Slave back-pressure: slot holds master 2's entry
        $display("[TB] step 3: slave backpressure");
        s_AWREADY_i = 1'b0;
        B_done_i    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("t3_ready", 64'(dsp_AWREADY_o), 64'd0);
            checkOutput("t3_wr_en", 64'(AW_fifo_order_wr_en_o), 64'd0);
            tick();
            checkOutput("t3_saddr",  64'(s_AWADDR_o), 64'h1020);
            checkOutput("t3_svalid", 64'(s_AWVALID_o), 64'd1);
        end
        s_AWREADY_i = 1'b1;
        #1;
        checkOutput("t3_refill_ready", 64'(dsp_AWREADY_o), 64'b001);
        checkOutput("t3_refill_wr",    64'(AW_fifo_order_wr_en_o), 64'd1);
        tick();
        checkOutput("t3_refill_addr", 64'(s_AWADDR_o), 64'h1000);

        // Order-FIFO stall blocks grants but not the pending handshake
        $display("[TB] step 4: order fifo stall");
        doReset();
        applyStimulus(0, 1'b1, 5'd7, 32'h200, 3'd1);
        #1;
        checkOutput("t4_load_ready", 64'(dsp_AWREADY_o), 64'b001);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 32'h0, 3'd0);
        applyStimulus(2, 1'b1, 5'd9, 32'h300, 3'd2);
        AW_stall_i = 1'b1;
        #1;
        checkOutput("t4_stall_ready", 64'(dsp_AWREADY_o), 64'd0);
        checkOutput("t4_stall_wr",    64'(AW_fifo_order_wr_en_o), 64'd0);
        s_AWREADY_i = 1'b1;
        #1;
        checkOutput("t4_stall_ready2", 64'(dsp_AWREADY_o), 64'd0);
        tick();
        checkOutput("t4_drained", 64'(s_AWVALID_o), 64'd0);
        AW_stall_i = 1'b0;
        #1;
        checkOutput("t4_rel_ready", 64'(dsp_AWREADY_o), 64'b100);
        checkOutput("t4_rel_mst",   64'(AW_mst_id_o), 64'd2);
        checkOutput("t4_rel_len",   64'(AW_AxLEN_o), 64'd2);
        tick();
        checkOutput("t4_svalid", 64'(s_AWVALID_o), 64'd1);
        checkOutput("t4_sawid",  64'(s_AWID_o), 64'h49);

        // Outstanding limit of 2
        $display("[TB] step 5: outstanding limit");
        doReset();
        applyStimulus(0, 1'b1, 5'd1, 32'h400, 3'd0);
        applyStimulus(1, 1'b1, 5'd2, 32'h500, 3'd0);
        s_AWREADY_i = 1'b1;
        #1;
        checkOutput("t5_g0", 64'(dsp_AWREADY_o), 64'b001);
        tick();
        checkOutput("t5_g1", 64'(dsp_AWREADY_o), 64'b010);
        tick();
        checkOutput("t5_full", 64'(dsp_AWREADY_o), 64'd0);
        B_done_i = 1'b1;
        #1;
        checkOutput("t5_full_bdone", 64'(dsp_AWREADY_o), 64'd0);
        tick();
        B_done_i = 1'b0;
        #1;
        checkOutput("t5_after_b", 64'(dsp_AWREADY_o), 64'b001);
        B_done_i = 1'b1;
        tick();
        B_done_i = 1'b0;
        #1;
        checkOutput("t5_after_both", 64'(dsp_AWREADY_o), 64'b010);
        tick();
        checkOutput("t5_full_again", 64'(dsp_AWREADY_o), 64'd0);

        // Asynchronous reset with the slot valid
        $display("[TB] step 6: async reset");
        dsp_AWVALID_i = '0;
        s_AWREADY_i   = 1'b0;
        #1;
        checkOutput("t6_pre_valid", 64'(s_AWVALID_o), 64'd1);
        #2;
        ARESETn_i = 1'b0;
        #1;
        checkOutput("t6_async_valid", 64'(s_AWVALID_o), 64'd0);
        checkOutput("t6_async_addr",  64'(s_AWADDR_o), 64'd0);
        tick();
        ARESETn_i     = 1'b1;
        dsp_AWVALID_i = 3'b111;
        s_AWREADY_i   = 1'b1;
        #1;
        checkOutput("t6_post_ready", 64'(dsp_AWREADY_o), 64'b001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
